// File: rtl/traffic_ctrl.sv
// rtl/traffic_ctrl.sv - one-hot traffic light phase controller with pedestrian, emergency and watchdog handling
//
// Ports:
//   clk        single clock, rising edge
//   reset      synchronous active-high reset
//   int_flags  per-state phase-expired flags from the light datapath (indexed by state bit)
//   ped_req    pedestrian request level, held by the requester until ped_ack
//   emg        emergency hold level
//   state      registered one-hot state: bit0 INIT, bit1 R, bit2 G, bit3 Y
//   cnt_rst    one-cycle datapath counter clear, high in the first cycle of a new state
//   ped_ack    one-cycle pedestrian acknowledge, high in the first R cycle that serves a request
//   cycles     count of completed R->G transitions, wraps 255->0
//   err        sticky watchdog error flag, cleared only by reset

module traffic_ctrl #(
    parameter int STATE_W = 4,
    parameter int MIN_G   = 128,
    parameter int WDOG    = 2047
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [STATE_W-1:0] int_flags,
    input  logic               ped_req,
    input  logic               emg,
    output logic [STATE_W-1:0] state,
    output logic               cnt_rst,
    output logic               ped_ack,
    output logic [7:0]         cycles,
    output logic               err
);

    localparam int I_INIT = 0;
    localparam int I_R    = 1;
    localparam int I_G    = 2;
    localparam int I_Y    = 3;

    localparam logic [STATE_W-1:0] S_INIT = STATE_W'(1) << I_INIT;
    localparam logic [STATE_W-1:0] S_R    = STATE_W'(1) << I_R;
    localparam logic [STATE_W-1:0] S_G    = STATE_W'(1) << I_G;
    localparam logic [STATE_W-1:0] S_Y    = STATE_W'(1) << I_Y;

    // Last dwell value before the watchdog fires: the edge that would
    // bring dwell up to WDOG is the one that forces INIT.
    localparam logic [10:0] DWELL_LAST = 11'(WDOG - 1);
    // g_cnt value from which a pending pedestrian request may end green.
    localparam logic [8:0]  G_MIN_LAST = 9'(MIN_G - 1);

    logic [STATE_W-1:0] state_nxt;
    logic [10:0]        dwell;
    logic [7:0]         g_cnt;
    logic               ped_pend;
    logic               ped_req_q;

    logic in_g;
    logic in_r;
    logic dwell_adv;
    logic wdog_trip;
    logic ped_short;
    logic ped_rise;
    logic state_chg;
    logic enter_g;
    logic enter_r;
    logic r_to_g;

    assign in_g      = (state == S_G);
    assign in_r      = (state == S_R);

    // R is held indefinitely under emergency, so its dwell must freeze
    // there or the watchdog would fire on a legitimate hold.
    assign dwell_adv = !(in_r && emg);
    assign wdog_trip = dwell_adv && (dwell == DWELL_LAST);

    assign ped_short = in_g && ped_pend && ({1'b0, g_cnt} >= G_MIN_LAST);
    assign ped_rise  = ped_req && !ped_req_q;

    // Priority: watchdog, then emergency, then the phase flag, then the
    // pedestrian shortening. In G the last three all lead to Y; the
    // ordering matters in R, where emergency overrides the flag.
    always_comb begin
        state_nxt = state;
        if (wdog_trip) begin
            state_nxt = S_INIT;
        end else begin
            case (state)
                S_INIT: begin
                    if (int_flags[I_INIT])
                        state_nxt = S_G;
                end
                S_G: begin
                    if (emg || int_flags[I_G] || ped_short)
                        state_nxt = S_Y;
                end
                S_Y: begin
                    if (int_flags[I_Y])
                        state_nxt = S_R;
                end
                S_R: begin
                    if (!emg && int_flags[I_R])
                        state_nxt = S_G;
                end
                default: state_nxt = S_INIT;
            endcase
        end
    end

    // A watchdog trip in INIT keeps the same state value but still counts
    // as a transition so the datapath sees a clear and dwell restarts.
    assign state_chg = (state_nxt != state) || wdog_trip;
    assign enter_g   = (state_nxt == S_G) && !in_g;
    assign enter_r   = (state_nxt == S_R) && !in_r;
    assign r_to_g    = in_r && (state_nxt == S_G);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_INIT;
            cnt_rst   <= 1'b0;
            ped_ack   <= 1'b0;
            cycles    <= 8'd0;
            err       <= 1'b0;
            dwell     <= 11'd0;
            g_cnt     <= 8'd0;
            ped_pend  <= 1'b0;
            ped_req_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt_rst   <= state_chg;
            ped_req_q <= ped_req;

            if (state_chg)
                dwell <= 11'd0;
            else if (dwell_adv)
                dwell <= dwell + 11'd1;

            if (enter_g)
                g_cnt <= 8'd0;
            else if (in_g && (g_cnt != 8'hFF))
                g_cnt <= g_cnt + 8'd1;

            if (r_to_g)
                cycles <= cycles + 8'd1;

            if (wdog_trip)
                err <= 1'b1;

            // A pending request is served on R entry; rising edges seen
            // while already pending are absorbed.
            ped_ack <= enter_r && ped_pend;
            if (wdog_trip)
                ped_pend <= 1'b0;
            else if (enter_r && ped_pend)
                ped_pend <= 1'b0;
            else if (ped_rise)
                ped_pend <= 1'b1;
        end
    end

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb/tb_traffic_ctrl.sv - directed self-checking bench for traffic_ctrl

module tb_traffic_ctrl;

    localparam logic [3:0] ST_INIT = 4'b0001;
    localparam logic [3:0] ST_R    = 4'b0010;
    localparam logic [3:0] ST_G    = 4'b0100;
    localparam logic [3:0] ST_Y    = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] int_flags;
    logic       ped_req;
    logic       emg;
    logic [3:0] state;
    logic       cnt_rst;
    logic       ped_ack;
    logic [7:0] cycles;
    logic       err;

    int n_chk  = 0;
    int n_fail = 0;

    traffic_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .int_flags (int_flags),
        .ped_req   (ped_req),
        .emg       (emg),
        .state     (state),
        .cnt_rst   (cnt_rst),
        .ped_ack   (ped_ack),
        .cycles    (cycles),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic one_loop();
        int_flags = ST_G; tick(1);
        int_flags = ST_Y; tick(1);
        int_flags = ST_R; tick(1);
        int_flags = 4'b0000;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; int_flags = 4'b0000; ped_req = 1'b0; emg = 1'b0;
        tick(2);
        chk("rst_state",   32'(state),   32'(ST_INIT));
        chk("rst_cnt_rst", 32'(cnt_rst), 32'd0);
        chk("rst_ped_ack", 32'(ped_ack), 32'd0);
        chk("rst_cycles",  32'(cycles),  32'd0);
        chk("rst_err",     32'(err),     32'd0);

        // INIT -> G
        reset = 1'b0; tick(1);
        chk("init_hold", 32'(state), 32'(ST_INIT));
        int_flags = ST_INIT; tick(1);
        chk("init_to_g", 32'(state), 32'(ST_G));
        chk("init_to_g_cr", 32'(cnt_rst), 32'd1);
        int_flags = 4'b0000; tick(1);
        chk("g_cr_low", 32'(cnt_rst), 32'd0);
        int_flags = 4'b1011; tick(1);
        chk("g_ignores_other_flags", 32'(state), 32'(ST_G));
        chk("g_ignores_cr", 32'(cnt_rst), 32'd0);

        // full loop G->Y->R->G
        int_flags = ST_G; tick(1);
        chk("loop_y", 32'(state), 32'(ST_Y));
        chk("loop_y_cr", 32'(cnt_rst), 32'd1);
        int_flags = ST_Y; tick(1);
        chk("loop_r", 32'(state), 32'(ST_R));
        chk("loop_r_cr", 32'(cnt_rst), 32'd1);
        chk("loop_r_ack", 32'(ped_ack), 32'd0);
        int_flags = ST_R; tick(1);
        chk("loop_g", 32'(state), 32'(ST_G));
        chk("loop_g_cr", 32'(cnt_rst), 32'd1);
        chk("loop_cycles", 32'(cycles), 32'd1);
        int_flags = 4'b0000; tick(1);
        chk("loop_cr_low", 32'(cnt_rst), 32'd0);

        // pedestrian shortening: now in G cycle 1, raise request at cycle 10
        tick(9);
        ped_req = 1'b1;
        tick(117);
        chk("ped_g_cycle127", 32'(state), 32'(ST_G));
        tick(1);
        chk("ped_short_y", 32'(state), 32'(ST_Y));
        chk("ped_short_cr", 32'(cnt_rst), 32'd1);
        int_flags = ST_Y; tick(1);
        chk("ped_r", 32'(state), 32'(ST_R));
        chk("ped_ack_pulse", 32'(ped_ack), 32'd1);
        int_flags = 4'b0000; ped_req = 1'b0; tick(1);
        chk("ped_ack_low", 32'(ped_ack), 32'd0);
        int_flags = ST_R; tick(1);
        chk("ped_back_g", 32'(state), 32'(ST_G));
        chk("ped_cycles", 32'(cycles), 32'd2);
        int_flags = 4'b0000; tick(140);
        chk("ped_pend_cleared", 32'(state), 32'(ST_G));

        // emergency: G->Y->R, R held with its flag up
        emg = 1'b1; int_flags = ST_R | ST_Y; tick(1);
        chk("emg_g_to_y", 32'(state), 32'(ST_Y));
        tick(1);
        chk("emg_y_to_r", 32'(state), 32'(ST_R));
        tick(3000);
        chk("emg_r_held", 32'(state), 32'(ST_R));
        chk("emg_no_err", 32'(err), 32'd0);
        emg = 1'b0; tick(1);
        chk("emg_release_g", 32'(state), 32'(ST_G));
        chk("emg_release_cr", 32'(cnt_rst), 32'd1);
        chk("emg_cycles", 32'(cycles), 32'd3);

        // watchdog in Y; a request raised in Y must be dropped by the trip
        int_flags = ST_G; tick(1);
        chk("wd_enter_y", 32'(state), 32'(ST_Y));
        int_flags = 4'b0000; ped_req = 1'b1;
        tick(2046);
        chk("wd_y_2046", 32'(state), 32'(ST_Y));
        chk("wd_err_before", 32'(err), 32'd0);
        tick(1);
        chk("wd_init", 32'(state), 32'(ST_INIT));
        chk("wd_cr", 32'(cnt_rst), 32'd1);
        chk("wd_err", 32'(err), 32'd1);
        tick(1);
        chk("wd_cr_low", 32'(cnt_rst), 32'd0);
        int_flags = ST_INIT; tick(1);
        int_flags = ST_G; tick(1);
        int_flags = ST_Y; tick(1);
        chk("wd_r", 32'(state), 32'(ST_R));
        chk("wd_no_ack", 32'(ped_ack), 32'd0);
        chk("wd_err_sticky", 32'(err), 32'd1);
        int_flags = ST_R; tick(1);
        chk("wd_cycles", 32'(cycles), 32'd4);
        int_flags = 4'b0000; ped_req = 1'b0;

        // reset clears err; then 256 loops wrap cycles
        reset = 1'b1; tick(1);
        chk("rst2_err", 32'(err), 32'd0);
        chk("rst2_cycles", 32'(cycles), 32'd0);
        chk("rst2_state", 32'(state), 32'(ST_INIT));
        reset = 1'b0; int_flags = ST_INIT; tick(1);
        int_flags = 4'b0000;
        for (int i = 0; i < 255; i++) one_loop();
        chk("wrap_255", 32'(cycles), 32'd255);
        one_loop();
        chk("wrap_0", 32'(cycles), 32'd0);
        chk("wrap_state", 32'(state), 32'(ST_G));

        // reset in R with a pending request and emergency active
        int_flags = ST_G; tick(1);
        int_flags = ST_Y; tick(1);
        int_flags = 4'b0000;
        chk("rr_in_r", 32'(state), 32'(ST_R));
        ped_req = 1'b1; emg = 1'b1; tick(1);
        chk("rr_r_hold", 32'(state), 32'(ST_R));
        chk("rr_no_ack", 32'(ped_ack), 32'd0);
        reset = 1'b1; tick(1);
        chk("rr_state", 32'(state), 32'(ST_INIT));
        chk("rr_cr", 32'(cnt_rst), 32'd0);
        chk("rr_ack", 32'(ped_ack), 32'd0);
        ped_req = 1'b0; emg = 1'b0; tick(1);
        reset = 1'b0; tick(1);
        emg = 1'b1; int_flags = ST_INIT; tick(1);
        chk("rr_init_emg_g", 32'(state), 32'(ST_G));
        emg = 1'b0; int_flags = ST_G; tick(1);
        int_flags = ST_Y; tick(1);
        chk("rr_back_r", 32'(state), 32'(ST_R));
        chk("rr_never_ack", 32'(ped_ack), 32'd0);
        int_flags = 4'b0000; tick(1);
        chk("rr_never_ack2", 32'(ped_ack), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
